// File: rtl/spec_framer.sv
// rtl/spec_framer.sv - Nios-side spectrum packetiser: frame sync, decimation, NaN/Inf scrub, Avalon-ST out
module spec_framer #(
   parameter int DATA_W   = 32,
   parameter int LEN      = 8192,
   parameter int CNT_W    = 16,
   parameter int NCH      = 1,
   parameter int CH_W     = 1,
   parameter int ZERO_NAN = 1
) (
   input  logic              nios_clk,
   input  logic              reset,
   input  logic              cfg_en,
   input  logic [7:0]        cfg_skip,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_sop,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_sop,
   output logic              out_eop,
   output logic [1:0]        out_empty,
   output logic [CH_W-1:0]   out_channel,
   output logic [7:0]        resync_err,
   output logic [15:0]       nan_cnt
);

   localparam logic [1:0] ST_SYNC = 2'd0;
   localparam logic [1:0] ST_PASS = 2'd1;
   localparam logic [1:0] ST_SKIP = 2'd2;

   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(LEN - 1);
   localparam logic [CNT_W-1:0] CNT_SECOND = CNT_W'(LEN - 2);
   localparam logic [CH_W-1:0]  CH_LAST    = CH_W'(NCH - 1);

   logic [1:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [7:0]        skip_q, skip_d;
   logic [CH_W-1:0]   ch_q, ch_d;
   logic              ov_q, ov_d;
   logic [DATA_W-1:0] od_q, od_d;
   logic              osop_q, osop_d;
   logic              oeop_q, oeop_d;
   logic [CH_W-1:0]   och_q, och_d;
   logic [7:0]        rerr_q, rerr_d;
   logic [15:0]       nan_q, nan_d;

   logic accept;
   logic load;
   logic frame_end;
   logic first_word;
   logic is_nan;

   // Exponent all-ones marks Inf or NaN in IEEE-754 single precision
   generate
      if (ZERO_NAN != 0 && DATA_W >= 31) begin : g_nan
         assign is_nan = &in_data[30:23];
      end else begin : g_no_nan
         assign is_nan = 1'b0;
      end
   endgenerate

   assign frame_end  = (cnt_q == '0);
   assign first_word = (cnt_q == CNT_LAST);
   assign accept     = in_valid & in_ready;

   // Only the first word of a frame in SYNC and every word in PASS reach the output register
   assign load = accept & ((state_q == ST_PASS) |
                           ((state_q == ST_SYNC) & in_sop & cfg_en));

   // FIFO read request; in SYNC the frame-start word is held back while the
   // previous packet's last word is still waiting in the output register
   always_comb begin
      case (state_q)
         ST_PASS: in_ready = ~ov_q | out_ready;
         ST_SYNC: in_ready = ~(in_sop & cfg_en & ov_q & ~out_ready);
         default: in_ready = 1'b1;
      endcase
   end

   // Next-state logic for the framer, word counter, output stage and error counters
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      skip_d  = skip_q;
      ch_d    = ch_q;
      ov_d    = ov_q;
      od_d    = od_q;
      osop_d  = osop_q;
      oeop_d  = oeop_q;
      och_d   = och_q;
      rerr_d  = rerr_q;
      nan_d   = nan_q;

      if (ov_q & out_ready) begin
         ov_d = 1'b0;
      end

      if (load) begin
         ov_d   = 1'b1;
         od_d   = is_nan ? '0 : in_data;
         och_d  = ch_q;
         osop_d = (state_q == ST_SYNC) | first_word;
         oeop_d = (state_q == ST_PASS) & frame_end;
         if (is_nan && nan_q != 16'hFFFF) begin
            nan_d = nan_q + 16'd1;
         end
      end

      if (accept) begin
         case (state_q)
            ST_SYNC: begin
               if (in_sop & cfg_en) begin
                  state_d = ST_PASS;
                  cnt_d   = CNT_SECOND;
               end
            end
            ST_PASS, ST_SKIP: begin
               // Frame length wins over a misplaced start flag; just count it
               if (in_sop && !first_word && rerr_q != 8'hFF) begin
                  rerr_d = rerr_q + 8'd1;
               end
               if (frame_end) begin
                  cnt_d = CNT_LAST;
                  if (state_q == ST_PASS) begin
                     ch_d   = (ch_q == CH_LAST) ? '0 : ch_q + CH_W'(1);
                     skip_d = cfg_skip;
                     if (cfg_skip != 8'd0) begin
                        state_d = ST_SKIP;
                     end else if (!cfg_en) begin
                        state_d = ST_SYNC;
                     end else begin
                        state_d = ST_PASS;
                     end
                  end else begin
                     skip_d = skip_q - 8'd1;
                     if (skip_q <= 8'd1) begin
                        state_d = cfg_en ? ST_PASS : ST_SYNC;
                     end
                  end
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
            default: begin
               state_d = ST_SYNC;
               cnt_d   = CNT_LAST;
            end
         endcase
      end
   end

   // State and output registers, cleared asynchronously
   always_ff @(posedge nios_clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_SYNC;
         cnt_q   <= CNT_LAST;
         skip_q  <= 8'd0;
         ch_q    <= '0;
         ov_q    <= 1'b0;
         od_q    <= '0;
         osop_q  <= 1'b0;
         oeop_q  <= 1'b0;
         och_q   <= '0;
         rerr_q  <= 8'd0;
         nan_q   <= 16'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         skip_q  <= skip_d;
         ch_q    <= ch_d;
         ov_q    <= ov_d;
         od_q    <= od_d;
         osop_q  <= osop_d;
         oeop_q  <= oeop_d;
         och_q   <= och_d;
         rerr_q  <= rerr_d;
         nan_q   <= nan_d;
      end
   end

   assign out_data    = od_q;
   assign out_valid   = ov_q;
   assign out_sop     = osop_q;
   assign out_eop     = oeop_q;
   assign out_empty   = 2'b00;
   assign out_channel = och_q;
   assign resync_err  = rerr_q;
   assign nan_cnt     = nan_q;

endmodule
